// File: rtl/door_lock_pkg.sv
// door_lock_pkg: shared state encoding, widths and helpers for the door-lock sequencer
package door_lock_pkg;
  localparam int BYTE_W = 8;
  localparam int FAIL_W = 4;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_PROGRAM  = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that flags expiry when it reaches zero
module lock_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: keypad code-entry sequencer with unlock hold, failure lockout and reprogramming
module door_lock_ctrl
  import door_lock_pkg::*;
#(
  parameter int CODE_LEN    = 4,
  parameter logic [8*CODE_LEN-1:0] DEFAULT_CODE = (8*CODE_LEN)'(32'h34333231),
  parameter int MAX_FAILS   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int UNLOCK_CYC  = 5000,
  parameter int LOCKOUT_CYC = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_start,
  input  logic        i_prog,
  output logic        o_unlock,
  output logic        o_alarm,
  output logic [3:0]  o_fail_cnt,
  output logic [2:0]  o_state
);
  localparam int CW = BYTE_W * CODE_LEN;
  localparam int IW = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2((UNLOCK_CYC > LOCKOUT_CYC ? UNLOCK_CYC : LOCKOUT_CYC) + 1);
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic mism;
  logic [CW-1:0] code, shadow, shadow_nxt;
  logic accept, last, neq, ib_exp, ib_load, ib_en, hold_exp, hold_en;
  logic [HW-1:0] hold_val;
  logic [FAIL_W-1:0] fail_inc;
  assign accept   = i_rx_done && (state == S_IDLE || state == S_COLLECT || state == S_PROGRAM);
  assign last     = idx == IW'(CODE_LEN - 1);
  assign neq      = code[idx*BYTE_W +: BYTE_W] != i_rx_data;
  assign fail_inc = sat_inc(o_fail_cnt);
  assign ib_load  = accept || (state == S_UNLOCKED && i_prog);
  assign ib_en    = state == S_COLLECT || state == S_PROGRAM;
  assign hold_en  = state == S_UNLOCKED || state == S_LOCKOUT;
  assign hold_val = mism ? HW'(LOCKOUT_CYC - 1) : HW'(UNLOCK_CYC - 1);
  assign o_state  = state;
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[idx*BYTE_W +: BYTE_W] = i_rx_data;
    nxt = state;
    case (state)
      S_IDLE:     nxt = accept ? (last ? S_CHECK : S_COLLECT) : S_IDLE;
      S_COLLECT:  nxt = accept ? (last ? S_CHECK : S_COLLECT) : ib_exp ? S_IDLE : S_COLLECT;
      S_CHECK:    nxt = !mism ? S_UNLOCKED : fail_inc == FAIL_W'(MAX_FAILS) ? S_LOCKOUT : S_IDLE;
      S_UNLOCKED: nxt = i_prog ? S_PROGRAM : hold_exp ? S_IDLE : S_UNLOCKED;
      S_PROGRAM:  nxt = accept ? (last ? S_IDLE : S_PROGRAM) : ib_exp ? S_IDLE : S_PROGRAM;
      S_LOCKOUT:  nxt = hold_exp ? S_IDLE : S_LOCKOUT;
      default:    nxt = S_IDLE;
    endcase
  end
  // a byte arriving in the expiry cycle reloads the timer, so it always beats the abort
  lock_timer #(.W(TW)) u_byte_timer (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .load(ib_load), .load_val(TW'(TIMEOUT_CYC - 1)),
    .en(ib_en), .expired(ib_exp)
  );
  lock_timer #(.W(HW)) u_hold_timer (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .load(state == S_CHECK), .load_val(hold_val),
    .en(hold_en), .expired(hold_exp)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      mism       <= 1'b0;
      code       <= DEFAULT_CODE;
      shadow     <= '0;
      o_rx_start <= 1'b0;
      o_unlock   <= 1'b0;
      o_alarm    <= 1'b0;
      o_fail_cnt <= '0;
    end else begin
      state      <= nxt;
      o_rx_start <= nxt == S_IDLE || nxt == S_COLLECT || nxt == S_PROGRAM;
      o_unlock   <= nxt == S_UNLOCKED;
      o_alarm    <= nxt == S_LOCKOUT;
      if (accept) begin
        idx    <= last ? '0 : idx + 1'b1;
        mism   <= (state == S_COLLECT && mism) || neq;
        shadow <= shadow_nxt;
      end else if (nxt == S_IDLE) idx <= '0;
      if (state == S_PROGRAM && accept && last) code <= shadow_nxt;
      if (state == S_CHECK) o_fail_cnt <= mism ? fail_inc : '0;
      if (state == S_LOCKOUT && hold_exp) o_fail_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_door_lock_ctrl.sv
// tb_door_lock_ctrl: scoreboard bench; expected state transitions queued by stimulus, popped by a monitor
module tb_door_lock_ctrl;
  import door_lock_pkg::*;
  localparam logic [31:0] GOOD = 32'h34333231;
  localparam logic [31:0] BAD  = 32'h35333231;
  localparam logic [31:0] NEWC = 32'hDDCCBBAA;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_rx_done = 1'b0, i_prog = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic o_rx_start, o_unlock, o_alarm;
  logic [3:0] o_fail_cnt;
  logic [2:0] o_state;
  typedef struct {
    logic [2:0] st;
    logic rx, unl, alm;
    logic [3:0] fail;
    int dwell;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_bad = 0, cyc = 0, last_chg = 0;
  logic mon_on = 1'b0;
  logic [2:0] prev = 3'd0;
  always #5 i_clk = ~i_clk;
  door_lock_ctrl #(
    .CODE_LEN(4), .MAX_FAILS(3), .TIMEOUT_CYC(20), .UNLOCK_CYC(10), .LOCKOUT_CYC(30)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .o_rx_start(o_rx_start), .i_prog(i_prog), .o_unlock(o_unlock), .o_alarm(o_alarm),
    .o_fail_cnt(o_fail_cnt), .o_state(o_state)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic exp_tr(input logic [2:0] st, input logic [3:0] fail, input int dwell);
    exp_t e;
    e.st = st; e.rx = st inside {3'd0, 3'd1, 3'd4}; e.unl = st == 3'd3; e.alm = st == 3'd5;
    e.fail = fail; e.dwell = dwell;
    q.push_back(e);
  endtask
  task automatic exp_rst();
    exp_t e;
    e.st = 3'd0; e.rx = 1'b0; e.unl = 1'b0; e.alm = 1'b0; e.fail = 4'd0; e.dwell = 0;
    q.push_back(e);
  endtask
  task automatic tick();
    @(posedge i_clk); #1;
  endtask
  task automatic send(input logic [7:0] b);
    i_rx_data = b; i_rx_done = 1'b1; tick(); i_rx_done = 1'b0;
    repeat (3) tick();
  endtask
  task automatic send_code(input logic [31:0] c);
    for (int k = 0; k < 4; k++) send(c[8*k +: 8]);
  endtask
  task automatic prog_pulse();
    i_prog = 1'b1; tick(); i_prog = 1'b0;
  endtask
  task automatic unlock_seq(input logic [3:0] f);
    exp_tr(S_COLLECT, f, 0); exp_tr(S_CHECK, f, 12); exp_tr(S_UNLOCKED, 4'd0, 1);
  endtask
  task automatic fail_seq(input logic [3:0] f);
    exp_tr(S_COLLECT, f, 0); exp_tr(S_CHECK, f, 12); exp_tr(S_IDLE, f + 4'd1, 1);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_state", o_state, 0); chk("rst_unlock", o_unlock, 0); chk("rst_alarm", o_alarm, 0);
    chk("rst_fail_cnt", o_fail_cnt, 0); chk("rst_rx_start", o_rx_start, 0);
  endtask
  always @(negedge i_clk) begin : monitor
    exp_t e;
    cyc++;
    if (mon_on && o_state !== prev) begin
      if (q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_transition: got state %0d from %0d, none expected", o_state, prev);
      end else begin
        e = q.pop_front();
        chk($sformatf("state(exp %0d)", e.st), o_state, e.st);
        chk($sformatf("rx_unl_alm_fail(st %0d)", e.st), {o_rx_start, o_unlock, o_alarm, o_fail_cnt},
            {e.rx, e.unl, e.alm, e.fail});
        if (e.dwell != 0) chk($sformatf("dwell_before(st %0d)", e.st), cyc - last_chg, e.dwell);
      end
      prev = o_state;
      last_chg = cyc;
    end
  end
  initial begin
    repeat (2) tick();
    chk_reset_outputs();
    i_rst_n = 1'b1; tick();
    chk("rx_start_after_rst", o_rx_start, 1);
    last_chg = cyc; mon_on = 1'b1;
    // correct code: 2-cycle unlock latency, 10-cycle hold
    unlock_seq(0); exp_tr(S_IDLE, 0, 10);
    send_code(GOOD); repeat (12) tick();
    // three failures -> lockout; correct code during lockout ignored
    fail_seq(0); send_code(BAD);
    fail_seq(1); send_code(BAD);
    exp_tr(S_COLLECT, 2, 0); exp_tr(S_CHECK, 2, 12); exp_tr(S_LOCKOUT, 3, 1); exp_tr(S_IDLE, 0, 30);
    send_code(BAD); send_code(GOOD); repeat (20) tick();
    // inter-byte timeout keeps fail count, then correct code unlocks
    fail_seq(0); send_code(BAD);
    exp_tr(S_COLLECT, 1, 0); exp_tr(S_IDLE, 1, 24);
    send(8'h31); send(8'h32); repeat (22) tick();
    unlock_seq(1); exp_tr(S_IDLE, 0, 10);
    send_code(GOOD); repeat (12) tick();
    // reprogram to AA BB CC DD
    unlock_seq(0); exp_tr(S_PROGRAM, 0, 3); exp_tr(S_IDLE, 0, 13);
    send_code(GOOD); prog_pulse(); send_code(NEWC);
    fail_seq(0); send_code(GOOD);
    unlock_seq(1); exp_tr(S_IDLE, 0, 10);
    send_code(NEWC); repeat (12) tick();
    // reset mid-program restores the default code
    unlock_seq(0); exp_tr(S_PROGRAM, 0, 3); exp_rst();
    send_code(NEWC); prog_pulse(); send(8'hAA); send(8'hBB);
    i_rst_n = 1'b0; tick();
    chk_reset_outputs();
    tick(); i_rst_n = 1'b1; tick();
    chk("rx_start_after_rst2", o_rx_start, 1);
    unlock_seq(0); exp_tr(S_IDLE, 0, 10);
    send_code(GOOD); repeat (12) tick();
    // i_prog in the expiry cycle wins; program timeout leaves code; i_prog in IDLE ignored
    unlock_seq(0); exp_tr(S_PROGRAM, 0, 10); exp_tr(S_IDLE, 0, 20);
    send_code(GOOD); repeat (7) tick(); prog_pulse(); repeat (25) tick();
    prog_pulse(); repeat (3) tick();
    chk("idle_prog_ignored", o_state, S_IDLE);
    unlock_seq(0); exp_tr(S_IDLE, 0, 10);
    send_code(GOOD); repeat (14) tick();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
